// File: rtl/rr_arb_select_3_pkg.sv
// Shared constants and pointer arithmetic for the
// three-input round-robin arbiter.
package rr_arb_select_3_pkg;

   localparam int NUM_REQ = 3;
   localparam int PTR_W   = 2;

   function automatic logic [PTR_W-1:0] rr_next(
      input logic [PTR_W-1:0] k
   );
      return (k >= 2'd2) ? 2'd0 : k + 2'd1;
   endfunction

   // Offset j from pointer p, modulo the requester count
   function automatic logic [PTR_W-1:0] rr_add(
      input logic [PTR_W-1:0] p,
      input logic [PTR_W-1:0] j
   );
      logic [PTR_W:0] s;
      s = {1'b0, p} + {1'b0, j};
      if (s >= 3'(NUM_REQ))
         s = s - 3'(NUM_REQ);
      return s[PTR_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arb_select_3_if.sv
// Request/grant and output handshake bundle
// of the round-robin arbiter.
interface rr_arb_select_3_if #(
   parameter int dwidth = 32
);
   logic [dwidth-1:0] i0, i1, i2;
   logic              req0, req1, req2;
   logic              ack0, ack1, ack2;
   logic              enable0, enable1, enable2;
   logic [dwidth-1:0] o0;
   logic              o_valid;
   logic              o_ready;

   modport master (
      output i0, i1, i2,
      output req0, req1, req2,
      input  ack0, ack1, ack2,
      input  enable0, enable1, enable2,
      input  o0, o_valid,
      output o_ready
   );

   modport slave (
      input  i0, i1, i2,
      input  req0, req1, req2,
      output ack0, ack1, ack2,
      output enable0, enable1, enable2,
      output o0, o_valid,
      input  o_ready
   );
endinterface

// File: rtl/rr_arb_select_3_select.sv
// 3:1 one-hot select macrocell; AND-OR of the
// enabled inputs.
module select_3_1_wn #(
   parameter int w = 32
) (
   input  logic [w-1:0] d0,
   input  logic [w-1:0] d1,
   input  logic [w-1:0] d2,
   input  logic         e0,
   input  logic         e1,
   input  logic         e2,
   output logic [w-1:0] y
);
   assign y = ({w{e0}} & d0)
            | ({w{e1}} & d1)
            | ({w{e2}} & d2);
endmodule

// File: rtl/rr_arb_select_3.sv
// Three-input round-robin arbiter with a
// one-stage registered output.
module rr_arb_select_3
   import rr_arb_select_3_pkg::*;
#(
   parameter int dwidth = 32
) (
   input logic            clk,
   input logic            rst_n,
   rr_arb_select_3_if.slave bus
);

   logic [PTR_W-1:0]   ptr, p, j, gidx;
   logic [NUM_REQ-1:0] req, rot, gnt;
   logic [2*NUM_REQ-1:0] dbl;
   logic               load_en, hit;
   logic [dwidth-1:0]  sel, o0_q;
   logic               vld_q;

   assign req = {bus.req2, bus.req1, bus.req0};

   always_comb begin
      // Unreachable pointer code 3 behaves as 0
      p       = (ptr == 2'd3) ? 2'd0 : ptr;
      load_en = !vld_q || bus.o_ready;
      dbl     = {req, req} >> p;
      rot     = dbl[NUM_REQ-1:0];
      j       = 2'd0;
      if (rot[0])
         j = 2'd0;
      else if (rot[1])
         j = 2'd1;
      else if (rot[2])
         j = 2'd2;
      gidx = rr_add(p, j);
      hit  = rst_n && load_en && (|req);
      gnt  = hit ? (3'(1) << gidx) : '0;
   end

   select_3_1_wn #(
      .w (dwidth)
   ) u_sel (
      .d0 (bus.i0),
      .d1 (bus.i1),
      .d2 (bus.i2),
      .e0 (gnt[0]),
      .e1 (gnt[1]),
      .e2 (gnt[2]),
      .y  (sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o0_q  <= '0;
         vld_q <= 1'b0;
         ptr   <= '0;
      end else if (load_en) begin
         if (hit) begin
            o0_q  <= sel;
            vld_q <= 1'b1;
            ptr   <= rr_next(gidx);
         end else begin
            vld_q <= 1'b0;
         end
      end
   end

   assign bus.ack0    = gnt[0];
   assign bus.ack1    = gnt[1];
   assign bus.ack2    = gnt[2];
   assign bus.enable0 = gnt[0];
   assign bus.enable1 = gnt[1];
   assign bus.enable2 = gnt[2];
   assign bus.o0      = o0_q;
   assign bus.o_valid = vld_q;

endmodule

// File: tb/tb_rr_arb_select_3.sv
// Randomized and directed bench for the
// round-robin arbiter against a behavioural model.
module tb_rr_arb_select_3;

   logic clk = 1'b0;
   logic rst_n;

   rr_arb_select_3_if #(.dwidth(32)) bus ();

   rr_arb_select_3 #(
      .dwidth (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          mptr;
   bit          mvalid;
   logic [31:0] mo0;
   logic [31:0] sb[$];

   function automatic logic [2:0] reqv();
      return {bus.req2, bus.req1, bus.req0};
   endfunction

   function automatic logic [2:0] ackv();
      return {bus.ack2, bus.ack1, bus.ack0};
   endfunction

   function automatic logic [2:0] env();
      return {bus.enable2, bus.enable1, bus.enable0};
   endfunction

   function automatic logic [31:0] din(input int k);
      case (k)
         0:       return bus.i0;
         1:       return bus.i1;
         default: return bus.i2;
      endcase
   endfunction

   // First asserted request scanning from the pointer, or -1
   function automatic int exp_grant();
      bit ld;
      logic [2:0] r;
      ld = !mvalid || bus.o_ready;
      r  = reqv();
      if (!ld) return -1;
      for (int n = 0; n < 3; n++) begin
         int k;
         k = (mptr + n) % 3;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [2:0] onehot(input int g);
      return (g < 0) ? 3'b000 : 3'(1 << g);
   endfunction

   task automatic model_edge(input int g);
      if (g >= 0) begin
         mo0    = din(g);
         mvalid = 1'b1;
         mptr   = (g + 1) % 3;
      end else if (!mvalid || bus.o_ready) begin
         mvalid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] r);
      bus.req0 = r[0];
      bus.req1 = r[1];
      bus.req2 = r[2];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_req(3'b000);
      bus.o_ready = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      mptr   = 0;
      mvalid = 1'b0;
      mo0    = '0;
   endtask

   task automatic test_reset();
      int g;
      rst_n = 1'b0;
      set_req(3'b111);
      bus.i0 = 32'h0000_00A0;
      bus.i1 = 32'h0000_00B1;
      bus.i2 = 32'h0000_00C2;
      bus.o_ready = 1'b0;
      #2;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o0 !== 32'h0) begin
         $display("FAIL reset_state: got v=%b o0=%h want v=0 o0=0",
                  bus.o_valid, bus.o0);
         miscompares++;
      end
      vectors++;
      if (ackv() !== 3'b000 || env() !== 3'b000) begin
         $display("FAIL reset_ack: got %b want 000", ackv());
         miscompares++;
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mptr   = 0;
      mvalid = 1'b0;
      mo0    = '0;
      bus.o_ready = 1'b1;
      #1;
      g = exp_grant();
      vectors++;
      if (ackv() !== 3'b001) begin
         $display("FAIL reset_first_ack: got %b want 001", ackv());
         miscompares++;
      end
      model_edge(g);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o0 !== 32'hA0) begin
         $display("FAIL reset_load: got v=%b o0=%h want v=1 o0=a0",
                  bus.o_valid, bus.o0);
         miscompares++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.o_valid !== 1'b0 || ackv() !== 3'b000) begin
         $display("FAIL reset_async: got v=%b ack=%b want v=0 ack=000",
                  bus.o_valid, ackv());
         miscompares++;
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mptr   = 0;
      mvalid = 1'b0;
      #1;
      vectors++;
      if (ackv() !== 3'b001) begin
         $display("FAIL reset_ptr0: got %b want 001", ackv());
         miscompares++;
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_o[4];
      int          exp_g[4];
      int          g;
      exp_o = '{32'hA0, 32'hB1, 32'hC2, 32'hA0};
      exp_g = '{0, 1, 2, 0};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_req(3'b111);
         bus.o_ready = 1'b1;
         #1;
         g = exp_grant();
         vectors++;
         if (ackv() !== onehot(exp_g[c]) || g != exp_g[c]) begin
            $display("FAIL rr_ack[%0d]: got %b want %b",
                     c, ackv(), onehot(exp_g[c]));
            miscompares++;
         end
         model_edge(g);
         vectors++;
         if (bus.o_valid !== 1'b1 || bus.o0 !== exp_o[c]
             || bus.o0 !== mo0) begin
            $display("FAIL rr_o0[%0d]: got v=%b o0=%h want v=1 o0=%h",
                     c, bus.o_valid, bus.o0, exp_o[c]);
            miscompares++;
         end
      end
   endtask

   task automatic test_ptr_skip();
      logic [2:0] pat[4];
      logic [2:0] want[4];
      int         g;
      pat  = '{3'b001, 3'b101, 3'b001, 3'b111};
      want = '{3'b001, 3'b100, 3'b001, 3'b010};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_req(pat[c]);
         bus.o_ready = 1'b1;
         #1;
         g = exp_grant();
         vectors++;
         if (ackv() !== want[c] || onehot(g) !== want[c]) begin
            $display("FAIL skip_ack[%0d]: got %b want %b",
                     c, ackv(), want[c]);
            miscompares++;
         end
         model_edge(g);
      end
   endtask

   task automatic test_back_pressure();
      int g;
      do_reset();
      @(negedge clk);
      set_req(3'b001);
      bus.i0 = 32'h11;
      #1;
      g = exp_grant();
      model_edge(g);
      @(negedge clk);
      set_req(3'b010);
      bus.i1 = 32'h22;
      for (int c = 0; c < 3; c++) begin
         #1;
         g = exp_grant();
         vectors++;
         if (bus.ack1 !== 1'b0 || bus.o0 !== 32'h11
             || bus.o_valid !== 1'b1) begin
            $display("FAIL bp_stall[%0d]: got ack1=%b o0=%h want 0/11",
                     c, bus.ack1, bus.o0);
            miscompares++;
         end
         model_edge(g);
         @(negedge clk);
      end
      bus.o_ready = 1'b1;
      #1;
      g = exp_grant();
      vectors++;
      if (bus.ack1 !== 1'b1) begin
         $display("FAIL bp_release: got ack1=%b want 1", bus.ack1);
         miscompares++;
      end
      model_edge(g);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o0 !== 32'h22) begin
         $display("FAIL bp_word: got o0=%h want 22", bus.o0);
         miscompares++;
      end
   endtask

   task automatic test_idle_drain();
      int g;
      do_reset();
      @(negedge clk);
      set_req(3'b001);
      bus.i0 = 32'h55;
      bus.o_ready = 1'b1;
      #1;
      g = exp_grant();
      model_edge(g);
      @(negedge clk);
      set_req(3'b000);
      #1;
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o0 !== 32'h55) begin
         $display("FAIL idle_word: got v=%b o0=%h want v=1 o0=55",
                  bus.o_valid, bus.o0);
         miscompares++;
      end
      g = exp_grant();
      model_edge(g);
      vectors++;
      if (bus.o_valid !== 1'b0) begin
         $display("FAIL idle_drop: got v=%b want 0", bus.o_valid);
         miscompares++;
      end
      @(negedge clk);
      set_req(3'b111);
      #1;
      vectors++;
      if (ackv() !== 3'b010) begin
         $display("FAIL idle_ptr: got %b want 010", ackv());
         miscompares++;
      end
      g = exp_grant();
      model_edge(g);
   endtask

   task automatic test_random();
      bit          pend[3];
      logic [31:0] w;
      int          g;
      do_reset();
      sb.delete();
      pend = '{1'b0, 1'b0, 1'b0};
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!pend[k]) begin
               pend[k] = ($urandom_range(1, 0) == 1);
               w = $urandom;
               case (k)
                  0:       begin bus.req0 = pend[k]; bus.i0 = w; end
                  1:       begin bus.req1 = pend[k]; bus.i1 = w; end
                  default: begin bus.req2 = pend[k]; bus.i2 = w; end
               endcase
            end
         end
         bus.o_ready = ($urandom_range(3, 0) != 0);
         #1;
         g = exp_grant();
         vectors++;
         if (ackv() !== onehot(g) || env() !== onehot(g)
             || $countones(env()) > 1) begin
            $display("FAIL rnd_grant[%0d]: got ack=%b en=%b want %b",
                     c, ackv(), env(), onehot(g));
            miscompares++;
         end
         if (mvalid && bus.o_ready && sb.size() > 0) begin
            w = sb.pop_front();
            vectors++;
            if (bus.o_valid !== 1'b1 || bus.o0 !== w) begin
               $display("FAIL rnd_deliver[%0d]: got %h want %h",
                        c, bus.o0, w);
               miscompares++;
            end
         end
         if (g >= 0) begin
            sb.push_back(din(g));
            pend[g] = 1'b0;
         end
         model_edge(g);
         vectors++;
         if (bus.o_valid !== mvalid
             || (mvalid && bus.o0 !== mo0)) begin
            $display("FAIL rnd_out[%0d]: got v=%b o0=%h want v=%b o0=%h",
                     c, bus.o_valid, bus.o0, mvalid, mo0);
            miscompares++;
         end
      end
   endtask

   initial begin
      set_req(3'b000);
      bus.i0 = '0;
      bus.i1 = '0;
      bus.i2 = '0;
      bus.o_ready = 1'b0;
      mptr   = 0;
      mvalid = 1'b0;
      mo0    = '0;
      test_reset();
      test_round_robin();
      test_ptr_skip();
      test_back_pressure();
      test_idle_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
